idma_cmd_arbiter: RTL and testbench
===================================

# idma_cmd_arbiter

Round-robin arbiter that shares the single internal-DMA command/status stream pair between up to four requesters, such as TX descriptor fetch, TX data fetch, RX data store and RX descriptor write-back. Each requester issues the DMA's 3-beat command (C1 direction/bytes/local address, C2 low address, C3 high address) on its own AXI-Stream port. The arbiter forwards whole commands atomically to the DMA, records the requester ID of every issued command in an in-order tag FIFO, and steers each 1-beat status word back to the requester that issued the command.

## Interface
Parameters:
- N, 3, number of requesters, legal range 2..4.
- DEPTH, 4, tag FIFO depth, i.e. maximum commands issued with status not yet returned; legal range 1..8.

Ports:
- Clock and reset: one clock; reset is synchronous and active-low.
- aclk  in  1  clock.
- aresetn  in  1  synchronous active-low reset, sampled on rising aclk.
- cmd_s_tdata  in  N*32  requester command words; requester i uses bits [32i+31:32i].
- cmd_s_tvalid  in  N  per-requester valid.
- cmd_s_tlast  in  N  per-requester last beat (beat 3).
- cmd_s_tready  out  N  per-requester ready.
- cmd_m_tdata  out  32  command word to the DMA.
- cmd_m_tvalid  out  1  valid to the DMA.
- cmd_m_tlast  out  1  last beat to the DMA.
- cmd_m_tready  in  1  ready from the DMA.
- stat_s_tdata  in  32  status word from the DMA.
- stat_s_tvalid  in  1  status valid from the DMA.
- stat_s_tlast  in  1  status last from the DMA.
- stat_s_tready  out  1  status ready to the DMA.
- stat_m_tdata  out  32  status word, broadcast to all requesters.
- stat_m_tlast  out  1  status last, broadcast to all requesters.
- stat_m_tvalid  out  N  per-requester status valid.
- stat_m_tready  in  N  per-requester status ready.
- outstanding  out  4  tag FIFO occupancy, range 0..DEPTH.
- busy  out  1  high in S_XFER or when outstanding is non-zero.

## Operation
State machine:
- S_IDLE:
  - Arbitrate when any cmd_s_tvalid is high and outstanding < DEPTH.
  - The winner is the first requester with tvalid set, searching from (last_grant+1) mod N upward with wrap.
  - Register grant and last_grant, then go to S_XFER.
  - With no request, or with the tag FIFO full, stay in S_IDLE.
- S_XFER: combinational pass-through of the granted port only.
  - cmd_m_tdata = cmd_s_tdata[grant] and cmd_m_tlast = cmd_s_tlast[grant].
  - cmd_m_tvalid = cmd_s_tvalid[grant].
  - cmd_s_tready[grant] = cmd_m_tready; every other cmd_s_tready is 0.
  - On a handshake with tlast: push grant into the tag FIFO and go to S_IDLE.
  - Beats without tlast keep the grant. A requester is never pre-empted mid-command, whatever the beat count.
- In S_IDLE, cmd_m_tvalid = 0 and all cmd_s_tready = 0.

Status routing:
- When the FIFO is non-empty, let h be the head tag.
  - stat_m_tvalid[h] = stat_s_tvalid; all other bits are 0.
  - stat_s_tready = stat_m_tready[h].
- When the FIFO is empty: stat_s_tready = 0 and stat_m_tvalid = 0. Stray status is held off and never dropped.
- Pop the head on a stat_s handshake with stat_s_tlast.
- stat_m_tdata and stat_m_tlast are wired straight from stat_s.

FIFO arithmetic:
- Read and write pointers are 3 bits and wrap at DEPTH (modulo DEPTH, not power-of-2 wrap).
- Occupancy counter is 4 bits.
- Push and pop in the same cycle leave the counter unchanged and update both pointers.
- Push while full is impossible by construction; the S_IDLE check guarantees it.

Reset (aresetn low at a rising edge):
- State goes to S_IDLE and last_grant to N-1, so requester 0 wins first.
- FIFO pointers and count go to 0.
- Reset mid-command abandons the partial command; the requester must resend it from C1.
- Reset values: cmd_m_tvalid 0, cmd_m_tlast 0, cmd_m_tdata 0, all cmd_s_tready 0, stat_s_tready 0, all stat_m_tvalid 0, outstanding 0, busy 0.

## Timing
- A request seen in S_IDLE at edge k gives cmd_m_tvalid at cycle k+1, a one-cycle arbitration latency.
- A 3-beat command with cmd_m_tready held high occupies 3 cycles in S_XFER.
- One mandatory S_IDLE bubble separates consecutive commands: back-to-back throughput is 3 beats per 4 cycles.
- Status path: zero latency, purely combinational.
- outstanding increments the cycle after the last-beat handshake and decrements the cycle after the status handshake.
- cmd_s_tvalid dropping mid-command stalls the transfer. The grant is held until tlast.

## Test plan
- Single requester: req1 sends C1=0x8040_0100, C2=0x1000_0000, C3=0 -> identical 3 beats on cmd_m starting one cycle later; outstanding goes to 1. A status 0x8040_0100 then reaches stat_m_tvalid[1] only, and outstanding returns to 0.
- Fairness: all 3 requesters continuously valid from reset -> grant order 0,1,2,0,1,2; each command is 4 cycles apart.
- FIFO full with DEPTH=2: issue 2 commands and withhold status -> the third requester's tready stays 0 and cmd_m_tvalid stays 0. Returning one status -> the third command issues within 2 cycles.
- Out-of-order backpressure: commands from req2 then req0; hold stat_m_tready[2]=0 -> stat_s_tready=0 and req0 receives nothing. Release -> req2 then req0 receive their statuses in order.
- Stalled beats plus simultaneous push/pop: toggle cmd_m_tready and the requester's tvalid mid-command -> no beat is lost or duplicated and no other requester is granted. A tlast push and a status pop in the same cycle leave outstanding unchanged.
- Reset mid-transfer: assert aresetn=0 after beat 2 -> next cycle all outputs take their reset values; a fresh command after reset is granted to requester 0 first.

Source files
------------

// File: rtl/idma_cmd_arbiter.sv
// Round-robin arbiter sharing one DMA command/status stream pair between N requesters.
// Commands pass through atomically; an in-order tag FIFO steers each status back to its issuer.
module idma_cmd_arbiter #(
    parameter int N     = 3,
    parameter int DEPTH = 4
) (
    input  logic            aclk,
    input  logic            aresetn,
    input  logic [N*32-1:0] cmd_s_tdata,
    input  logic [N-1:0]    cmd_s_tvalid,
    input  logic [N-1:0]    cmd_s_tlast,
    output logic [N-1:0]    cmd_s_tready,
    output logic [31:0]     cmd_m_tdata,
    output logic            cmd_m_tvalid,
    output logic            cmd_m_tlast,
    input  logic            cmd_m_tready,
    input  logic [31:0]     stat_s_tdata,
    input  logic            stat_s_tvalid,
    input  logic            stat_s_tlast,
    output logic            stat_s_tready,
    output logic [31:0]     stat_m_tdata,
    output logic            stat_m_tlast,
    output logic [N-1:0]    stat_m_tvalid,
    input  logic [N-1:0]    stat_m_tready,
    output logic [3:0]      outstanding,
    output logic            busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {S_IDLE, S_XFER} state_t;

    state_t      state, state_nx;
    logic [1:0]  grant, last_grant, winner;
    logic        found;
    logic        fifo_full, fifo_empty, push, pop;
    logic [2:0]  wr_ptr, rd_ptr;
    logic [3:0]  count;
    logic [1:0]  head;
    logic [1:0]  tag_mem [1 << AW];

    function automatic logic [2:0] ptr_inc(input logic [2:0] p);
        return (p == 3'(DEPTH - 1)) ? 3'd0 : p + 3'd1;
    endfunction

    assign fifo_full  = (count == 4'(DEPTH));
    assign fifo_empty = (count == 4'd0);
    assign head       = tag_mem[rd_ptr[AW-1:0]];

    // Search starts just after the previous winner so every requester is served in turn.
    always_comb begin
        int idx;
        idx    = 0;
        winner = last_grant;
        found  = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last_grant) + k) % N;
            if (!found && cmd_s_tvalid[idx]) begin
                found  = 1'b1;
                winner = 2'(idx);
            end
        end
    end

    // NOTE: every output of this block gets a default first so no path leaves a latch behind.
    always_comb begin
        state_nx     = state;
        cmd_m_tdata  = 32'd0;
        cmd_m_tvalid = 1'b0;
        cmd_m_tlast  = 1'b0;
        cmd_s_tready = '0;
        case (state)
            S_IDLE: begin
                if (found && !fifo_full) state_nx = S_XFER;
            end
            S_XFER: begin
                for (int i = 0; i < N; i++) begin
                    if (int'(grant) == i) begin
                        cmd_m_tdata     = cmd_s_tdata[32*i +: 32];
                        cmd_m_tvalid    = cmd_s_tvalid[i];
                        cmd_m_tlast     = cmd_s_tlast[i];
                        cmd_s_tready[i] = cmd_m_tready;
                    end
                end
                if (cmd_m_tvalid && cmd_m_tready && cmd_m_tlast) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign push = (state == S_XFER) && cmd_m_tvalid && cmd_m_tready && cmd_m_tlast;

    // Status with no command outstanding is held off rather than dropped.
    always_comb begin
        stat_s_tready = 1'b0;
        stat_m_tvalid = '0;
        if (!fifo_empty) begin
            for (int i = 0; i < N; i++) begin
                if (int'(head) == i) begin
                    stat_m_tvalid[i] = stat_s_tvalid;
                    stat_s_tready    = stat_m_tready[i];
                end
            end
        end
    end

    assign pop          = !fifo_empty && stat_s_tvalid && stat_s_tready && stat_s_tlast;
    assign stat_m_tdata = stat_s_tdata;
    assign stat_m_tlast = stat_s_tlast;
    assign outstanding  = count;
    assign busy         = (state == S_XFER) || !fifo_empty;

    // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state      <= S_IDLE;
            grant      <= 2'd0;
            last_grant <= 2'(N - 1);
            wr_ptr     <= 3'd0;
            rd_ptr     <= 3'd0;
            count      <= 4'd0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && found && !fifo_full) begin
                grant      <= winner;
                last_grant <= winner;
            end
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: tag storage has no reset; an entry is only read after a push has written it.
    always_ff @(posedge aclk) begin
        if (push) tag_mem[wr_ptr[AW-1:0]] <= grant;
    end

endmodule

// File: tb/tb_idma_cmd_arbiter.sv
// Directed bench for idma_cmd_arbiter (N=3, DEPTH=2): one task per scenario, inline comparisons.
module tb_idma_cmd_arbiter;

    localparam int N     = 3;
    localparam int DEPTH = 2;

    logic            aclk = 1'b0;
    logic            aresetn;
    logic [N*32-1:0] cmd_s_tdata;
    logic [N-1:0]    cmd_s_tvalid, cmd_s_tlast, cmd_s_tready;
    logic [31:0]     cmd_m_tdata;
    logic            cmd_m_tvalid, cmd_m_tlast, cmd_m_tready;
    logic [31:0]     stat_s_tdata, stat_m_tdata;
    logic            stat_s_tvalid, stat_s_tlast, stat_s_tready, stat_m_tlast;
    logic [N-1:0]    stat_m_tvalid, stat_m_tready;
    logic [3:0]      outstanding;
    logic            busy;

    int tests = 0;
    int fails = 0;

    idma_cmd_arbiter #(.N(N), .DEPTH(DEPTH)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_s_tdata(cmd_s_tdata), .cmd_s_tvalid(cmd_s_tvalid), .cmd_s_tlast(cmd_s_tlast),
        .cmd_s_tready(cmd_s_tready),
        .cmd_m_tdata(cmd_m_tdata), .cmd_m_tvalid(cmd_m_tvalid), .cmd_m_tlast(cmd_m_tlast),
        .cmd_m_tready(cmd_m_tready),
        .stat_s_tdata(stat_s_tdata), .stat_s_tvalid(stat_s_tvalid), .stat_s_tlast(stat_s_tlast),
        .stat_s_tready(stat_s_tready),
        .stat_m_tdata(stat_m_tdata), .stat_m_tlast(stat_m_tlast), .stat_m_tvalid(stat_m_tvalid),
        .stat_m_tready(stat_m_tready),
        .outstanding(outstanding), .busy(busy)
    );

    always #5 aclk = ~aclk;

    task automatic set_req(input int r, input logic v, input logic [31:0] d, input logic l);
        cmd_s_tvalid[r]          = v;
        cmd_s_tdata[32*r +: 32]  = d;
        cmd_s_tlast[r]           = l;
    endtask

    task automatic clear_inputs();
        cmd_s_tdata   = '0;
        cmd_s_tvalid  = '0;
        cmd_s_tlast   = '0;
        cmd_m_tready  = 1'b0;
        stat_s_tdata  = 32'd0;
        stat_s_tvalid = 1'b0;
        stat_s_tlast  = 1'b0;
        stat_m_tready = '0;
    endtask

    task automatic do_reset();
        @(negedge aclk);
        aresetn = 1'b0;
        clear_inputs();
        @(posedge aclk);
        @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
    endtask

    // Presents a 3-beat command on port r, advancing only on its own handshakes.
    task automatic send_cmd(input int r, input logic [31:0] w0, w1, w2, output bit ok);
        logic [31:0] w [3];
        logic        hs;
        int          b, budget;
        w[0] = w0; w[1] = w1; w[2] = w2;
        b = 0; budget = 0; ok = 1'b1;
        while (b < 3 && ok) begin
            @(negedge aclk);
            set_req(r, 1'b1, w[b], b == 2);
            #1;
            hs = cmd_s_tready[r];
            @(posedge aclk);
            if (hs) b++;
            budget++;
            if (budget > 20) ok = 1'b0;
        end
        #1;
        set_req(r, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic test_reset();
        @(negedge aclk);
        aresetn = 1'b0;
        clear_inputs();
        @(posedge aclk);
        @(negedge aclk);
        #1;
        tests++; if (cmd_m_tvalid !== 1'b0) begin fails++; $display("FAIL rst_cmd_m_tvalid: got %b expected 0", cmd_m_tvalid); end
        tests++; if (cmd_m_tlast !== 1'b0) begin fails++; $display("FAIL rst_cmd_m_tlast: got %b expected 0", cmd_m_tlast); end
        tests++; if (cmd_m_tdata !== 32'd0) begin fails++; $display("FAIL rst_cmd_m_tdata: got %h expected 0", cmd_m_tdata); end
        tests++; if (cmd_s_tready !== 3'b000) begin fails++; $display("FAIL rst_cmd_s_tready: got %b expected 000", cmd_s_tready); end
        tests++; if (stat_s_tready !== 1'b0) begin fails++; $display("FAIL rst_stat_s_tready: got %b expected 0", stat_s_tready); end
        tests++; if (stat_m_tvalid !== 3'b000) begin fails++; $display("FAIL rst_stat_m_tvalid: got %b expected 000", stat_m_tvalid); end
        tests++; if (outstanding !== 4'd0) begin fails++; $display("FAIL rst_outstanding: got %0d expected 0", outstanding); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b expected 0", busy); end
        aresetn = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        cmd_m_tready = 1'b1;
        @(negedge aclk); set_req(1, 1'b1, 32'h8040_0100, 1'b0); #1;
        tests++; if (cmd_m_tvalid !== 1'b0) begin fails++; $display("FAIL single_arb_latency: got %b expected 0", cmd_m_tvalid); end
        @(negedge aclk); #1;
        tests++; if ({cmd_m_tvalid, cmd_m_tdata} !== {1'b1, 32'h8040_0100}) begin fails++; $display("FAIL single_c1: got %b/%h expected 1/80400100", cmd_m_tvalid, cmd_m_tdata); end
        tests++; if (cmd_s_tready !== 3'b010) begin fails++; $display("FAIL single_ready: got %b expected 010", cmd_s_tready); end
        @(negedge aclk); set_req(1, 1'b1, 32'h1000_0000, 1'b0); #1;
        tests++; if ({cmd_m_tlast, cmd_m_tdata} !== {1'b0, 32'h1000_0000}) begin fails++; $display("FAIL single_c2: got %b/%h expected 0/10000000", cmd_m_tlast, cmd_m_tdata); end
        @(negedge aclk); set_req(1, 1'b1, 32'h0000_0000, 1'b1); #1;
        tests++; if ({cmd_m_tlast, cmd_m_tdata} !== {1'b1, 32'h0000_0000}) begin fails++; $display("FAIL single_c3: got %b/%h expected 1/00000000", cmd_m_tlast, cmd_m_tdata); end
        @(negedge aclk); set_req(1, 1'b0, 32'd0, 1'b0); #1;
        tests++; if (outstanding !== 4'd1) begin fails++; $display("FAIL single_outstanding1: got %0d expected 1", outstanding); end
        tests++; if ({cmd_m_tvalid, busy} !== 2'b01) begin fails++; $display("FAIL single_idle_busy: got %b expected 01", {cmd_m_tvalid, busy}); end
        stat_s_tdata = 32'h8040_0100; stat_s_tvalid = 1'b1; stat_s_tlast = 1'b1; stat_m_tready = 3'b111; #1;
        tests++; if (stat_m_tvalid !== 3'b010) begin fails++; $display("FAIL single_stat_route: got %b expected 010", stat_m_tvalid); end
        tests++; if ({stat_s_tready, stat_m_tdata} !== {1'b1, 32'h8040_0100}) begin fails++; $display("FAIL single_stat_data: got %b/%h expected 1/80400100", stat_s_tready, stat_m_tdata); end
        @(negedge aclk); stat_s_tvalid = 1'b0; #1;
        tests++; if ({outstanding, busy} !== 5'b0000_0) begin fails++; $display("FAIL single_drain: got %0d/%b expected 0/0", outstanding, busy); end
    endtask

    task automatic test_fairness();
        int beat [3];
        int ids [$];
        int starts [$];
        int bad;
        int g;
        logic [31:0] exp_d;
        beat = '{0, 0, 0};
        bad = 0;
        do_reset();
        cmd_m_tready = 1'b1;
        stat_s_tvalid = 1'b1; stat_s_tlast = 1'b1; stat_s_tdata = 32'h0000_0005; stat_m_tready = 3'b111;
        for (int cyc = 0; cyc < 24; cyc++) begin
            @(negedge aclk);
            for (int r = 0; r < N; r++)
                set_req(r, 1'b1, 32'hA000_0000 | (32'(r) << 8) | 32'(beat[r]), beat[r] == 2);
            #1;
            g = -1;
            for (int r = 0; r < N; r++) if (cmd_s_tready[r]) g = r;
            if ($countones(cmd_s_tready) > 1) bad++;
            if (cmd_m_tvalid && g >= 0) begin
                exp_d = 32'hA000_0000 | (32'(g) << 8) | 32'(beat[g]);
                if (cmd_m_tdata !== exp_d) bad++;
                if (beat[g] == 0) begin ids.push_back(g); starts.push_back(cyc); end
                beat[g] = (beat[g] + 1) % 3;
            end
        end
        @(negedge aclk); cmd_s_tvalid = '0; cmd_s_tlast = '0;
        @(negedge aclk); stat_s_tvalid = 1'b0; #1;
        tests++; if (bad !== 0) begin fails++; $display("FAIL fair_beats: got %0d bad beats expected 0", bad); end
        tests++; if (ids.size() !== 6) begin fails++; $display("FAIL fair_count: got %0d commands expected 6", ids.size()); end
        if (ids.size() == 6) begin
            tests++; if (starts[0] !== 1) begin fails++; $display("FAIL fair_first_start: got cycle %0d expected 1", starts[0]); end
            for (int k = 0; k < 6; k++) begin
                tests++; if (ids[k] !== k % 3) begin fails++; $display("FAIL fair_order[%0d]: got %0d expected %0d", k, ids[k], k % 3); end
            end
            for (int k = 1; k < 6; k++) begin
                tests++; if (starts[k] - starts[k-1] !== 4) begin fails++; $display("FAIL fair_spacing[%0d]: got %0d expected 4", k, starts[k] - starts[k-1]); end
            end
        end
        tests++; if (outstanding !== 4'd0) begin fails++; $display("FAIL fair_drain: got %0d expected 0", outstanding); end
    endtask

    task automatic test_fifo_full();
        bit ok0, ok1;
        int bad;
        bad = 0;
        do_reset();
        cmd_m_tready = 1'b1; stat_m_tready = 3'b111;
        send_cmd(0, 32'hF000_0001, 32'hF000_0002, 32'hF000_0003, ok0);
        send_cmd(1, 32'hF100_0001, 32'hF100_0002, 32'hF100_0003, ok1);
        tests++; if ({ok0, ok1} !== 2'b11) begin fails++; $display("FAIL full_issue_timeout: got %b expected 11", {ok0, ok1}); end
        @(negedge aclk); set_req(2, 1'b1, 32'hF200_0001, 1'b0);
        repeat (5) begin
            #1;
            if (cmd_s_tready !== 3'b000 || cmd_m_tvalid !== 1'b0) bad++;
            @(negedge aclk);
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL full_blocked: got %0d leaky cycles expected 0", bad); end
        tests++; if (outstanding !== 4'd2) begin fails++; $display("FAIL full_outstanding: got %0d expected 2", outstanding); end
        stat_s_tvalid = 1'b1; stat_s_tlast = 1'b1; stat_s_tdata = 32'h5000_0000; #1;
        tests++; if (stat_m_tvalid !== 3'b001) begin fails++; $display("FAIL full_stat0: got %b expected 001", stat_m_tvalid); end
        @(negedge aclk); stat_s_tvalid = 1'b0; #1;
        tests++; if ({cmd_m_tvalid, outstanding} !== {1'b0, 4'd1}) begin fails++; $display("FAIL full_after_pop: got %b/%0d expected 0/1", cmd_m_tvalid, outstanding); end
        @(negedge aclk); #1;
        tests++; if ({cmd_m_tvalid, cmd_s_tready} !== {1'b1, 3'b100}) begin fails++; $display("FAIL full_third_issue: got %b/%b expected 1/100", cmd_m_tvalid, cmd_s_tready); end
        @(negedge aclk); set_req(2, 1'b1, 32'hF200_0002, 1'b0);
        @(negedge aclk); set_req(2, 1'b1, 32'hF200_0003, 1'b1);
        @(posedge aclk); #1; set_req(2, 1'b0, 32'd0, 1'b0);
        @(negedge aclk); stat_s_tvalid = 1'b1; #1;
        tests++; if ({outstanding, stat_m_tvalid} !== {4'd2, 3'b010}) begin fails++; $display("FAIL full_stat1: got %0d/%b expected 2/010", outstanding, stat_m_tvalid); end
        @(negedge aclk); #1;
        tests++; if (stat_m_tvalid !== 3'b100) begin fails++; $display("FAIL full_stat2: got %b expected 100", stat_m_tvalid); end
        @(negedge aclk); stat_s_tvalid = 1'b0; #1;
        tests++; if (outstanding !== 4'd0) begin fails++; $display("FAIL full_drain: got %0d expected 0", outstanding); end
    endtask

    task automatic test_ooo_backpressure();
        bit ok2, ok0;
        do_reset();
        cmd_m_tready = 1'b1;
        send_cmd(2, 32'hC200_0001, 32'hC200_0002, 32'hC200_0003, ok2);
        send_cmd(0, 32'hC000_0001, 32'hC000_0002, 32'hC000_0003, ok0);
        tests++; if ({ok2, ok0} !== 2'b11) begin fails++; $display("FAIL ooo_issue_timeout: got %b expected 11", {ok2, ok0}); end
        @(negedge aclk);
        stat_m_tready = 3'b011; stat_s_tvalid = 1'b1; stat_s_tlast = 1'b1; stat_s_tdata = 32'h5200_0000; #1;
        tests++; if (stat_s_tready !== 1'b0) begin fails++; $display("FAIL ooo_held: got %b expected 0", stat_s_tready); end
        tests++; if (stat_m_tvalid !== 3'b100) begin fails++; $display("FAIL ooo_route_head: got %b expected 100", stat_m_tvalid); end
        repeat (3) @(negedge aclk);
        #1;
        tests++; if ({outstanding, stat_m_tvalid[0]} !== {4'd2, 1'b0}) begin fails++; $display("FAIL ooo_stalled: got %0d/%b expected 2/0", outstanding, stat_m_tvalid[0]); end
        stat_m_tready = 3'b111; #1;
        tests++; if (stat_s_tready !== 1'b1) begin fails++; $display("FAIL ooo_release: got %b expected 1", stat_s_tready); end
        @(negedge aclk); stat_s_tdata = 32'h5000_0000; #1;
        tests++; if ({stat_m_tvalid, stat_m_tdata} !== {3'b001, 32'h5000_0000}) begin fails++; $display("FAIL ooo_second: got %b/%h expected 001/50000000", stat_m_tvalid, stat_m_tdata); end
        @(negedge aclk); stat_s_tvalid = 1'b0; #1;
        tests++; if (outstanding !== 4'd0) begin fails++; $display("FAIL ooo_drain: got %0d expected 0", outstanding); end
    endtask

    task automatic test_stall_push_pop();
        bit ok;
        do_reset();
        cmd_m_tready = 1'b1; stat_m_tready = 3'b111;
        send_cmd(2, 32'hD200_0001, 32'hD200_0002, 32'hD200_0003, ok);
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL stall_prep_timeout: got %b expected 1", ok); end
        @(negedge aclk); set_req(1, 1'b1, 32'hAAAA_0001, 1'b0);
        @(negedge aclk); set_req(0, 1'b1, 32'h0000_00EE, 1'b0); #1;
        tests++; if ({cmd_m_tvalid, cmd_m_tdata, cmd_s_tready} !== {1'b1, 32'hAAAA_0001, 3'b010}) begin fails++; $display("FAIL stall_beat1: got %b/%h/%b expected 1/aaaa0001/010", cmd_m_tvalid, cmd_m_tdata, cmd_s_tready); end
        @(negedge aclk); set_req(1, 1'b1, 32'hAAAA_0002, 1'b0); cmd_m_tready = 1'b0; #1;
        tests++; if ({cmd_m_tvalid, cmd_s_tready} !== {1'b1, 3'b000}) begin fails++; $display("FAIL stall_dma_busy: got %b/%b expected 1/000", cmd_m_tvalid, cmd_s_tready); end
        @(negedge aclk); cmd_m_tready = 1'b1; set_req(1, 1'b0, 32'hAAAA_0002, 1'b0); #1;
        tests++; if ({cmd_m_tvalid, cmd_s_tready} !== {1'b0, 3'b010}) begin fails++; $display("FAIL stall_req_gap: got %b/%b expected 0/010", cmd_m_tvalid, cmd_s_tready); end
        @(negedge aclk); set_req(1, 1'b1, 32'hAAAA_0002, 1'b0); #1;
        tests++; if ({cmd_m_tvalid, cmd_m_tdata} !== {1'b1, 32'hAAAA_0002}) begin fails++; $display("FAIL stall_beat2: got %b/%h expected 1/aaaa0002", cmd_m_tvalid, cmd_m_tdata); end
        @(negedge aclk); set_req(1, 1'b1, 32'hAAAA_0003, 1'b1);
        stat_s_tvalid = 1'b1; stat_s_tlast = 1'b1; stat_s_tdata = 32'h5200_0000; #1;
        tests++; if ({cmd_m_tdata, cmd_m_tlast, stat_s_tready, outstanding} !== {32'hAAAA_0003, 1'b1, 1'b1, 4'd1}) begin fails++; $display("FAIL stall_beat3: got %h/%b/%b/%0d expected aaaa0003/1/1/1", cmd_m_tdata, cmd_m_tlast, stat_s_tready, outstanding); end
        @(negedge aclk); set_req(1, 1'b0, 32'd0, 1'b0); stat_s_tvalid = 1'b0; #1;
        tests++; if ({outstanding, cmd_m_tvalid} !== {4'd1, 1'b0}) begin fails++; $display("FAIL stall_push_pop: got %0d/%b expected 1/0", outstanding, cmd_m_tvalid); end
        stat_s_tvalid = 1'b1; #1;
        tests++; if (stat_m_tvalid !== 3'b010) begin fails++; $display("FAIL stall_new_head: got %b expected 010", stat_m_tvalid); end
        @(negedge aclk); stat_s_tvalid = 1'b0; #1;
        tests++; if (cmd_s_tready !== 3'b001) begin fails++; $display("FAIL stall_next_grant: got %b expected 001", cmd_s_tready); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cmd_m_tready = 1'b1;
        @(negedge aclk); set_req(1, 1'b1, 32'hB100_0001, 1'b0);
        @(negedge aclk);
        @(negedge aclk); set_req(1, 1'b1, 32'hB100_0002, 1'b0);
        @(negedge aclk); set_req(1, 1'b1, 32'hB100_0003, 1'b1); set_req(0, 1'b1, 32'hB000_0001, 1'b0);
        aresetn = 1'b0; #1;
        tests++; if (cmd_m_tvalid !== 1'b1) begin fails++; $display("FAIL rmid_sync: got %b expected 1", cmd_m_tvalid); end
        @(negedge aclk); #1;
        tests++; if ({cmd_m_tvalid, cmd_m_tlast, cmd_m_tdata} !== 34'd0) begin fails++; $display("FAIL rmid_cmd_m: got %b/%b/%h expected 0/0/0", cmd_m_tvalid, cmd_m_tlast, cmd_m_tdata); end
        tests++; if ({cmd_s_tready, stat_s_tready, stat_m_tvalid} !== 7'd0) begin fails++; $display("FAIL rmid_readies: got %b expected 0000000", {cmd_s_tready, stat_s_tready, stat_m_tvalid}); end
        tests++; if ({outstanding, busy} !== 5'd0) begin fails++; $display("FAIL rmid_count: got %0d/%b expected 0/0", outstanding, busy); end
        aresetn = 1'b1; set_req(1, 1'b1, 32'hB100_0001, 1'b0);
        @(negedge aclk); #1;
        tests++; if ({cmd_s_tready, cmd_m_tdata} !== {3'b001, 32'hB000_0001}) begin fails++; $display("FAIL rmid_req0_first: got %b/%h expected 001/b0000001", cmd_s_tready, cmd_m_tdata); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn = 1'b0;
        clear_inputs();
        test_reset();
        test_single();
        test_fairness();
        test_fifo_full();
        test_ooo_backpressure();
        test_stall_push_pop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
